// File: rtl/parking_timer.sv
// Parking-bay timer: tracks occupancy and parked time per bay, and bills a
// departing car (units * RATE, first unit charged on entry) one cycle after its exit.
module parking_timer #(
  parameter int NUM_SLOTS    = 4,
  parameter int SLOT_W       = 2,
  parameter int SEC_PER_UNIT = 60,
  parameter int RATE         = 10,
  parameter int SEC_W        = 16,
  parameter int UNIT_W       = 8,
  parameter int FEE_W        = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 enter_valid,
  input  logic [SLOT_W-1:0]    enter_slot,
  input  logic                 exit_valid,
  input  logic [SLOT_W-1:0]    exit_slot,
  input  logic [SLOT_W-1:0]    sel_slot,
  output logic [NUM_SLOTS-1:0] occupied,
  output logic [SLOT_W:0]      free_count,
  output logic [SEC_W-1:0]     sel_seconds,
  output logic                 fee_valid,
  output logic [FEE_W-1:0]     fee,
  output logic [SLOT_W-1:0]    fee_slot,
  output logic                 err
);

  localparam int SUB_W  = (SEC_PER_UNIT > 1) ? $clog2(SEC_PER_UNIT) : 1;
  localparam int PROD_W = UNIT_W + 32;

  typedef enum logic {BAY_FREE = 1'b0, BAY_OCC = 1'b1} bay_state_e;

  bay_state_e        state_q   [NUM_SLOTS];
  bay_state_e        state_d   [NUM_SLOTS];
  logic [SEC_W-1:0]  seconds_q [NUM_SLOTS];
  logic [SEC_W-1:0]  seconds_d [NUM_SLOTS];
  logic [SUB_W-1:0]  sub_q     [NUM_SLOTS];
  logic [SUB_W-1:0]  sub_d     [NUM_SLOTS];
  logic [UNIT_W-1:0] units_q   [NUM_SLOTS];
  logic [UNIT_W-1:0] units_d   [NUM_SLOTS];

  logic [SLOT_W:0]   free_count_q, free_count_d;
  logic              fee_valid_q, fee_valid_d;
  logic [FEE_W-1:0]  fee_q, fee_d;
  logic [SLOT_W-1:0] fee_slot_q, fee_slot_d;
  logic              err_q, err_d;

  logic              enter_ok, exit_ok;
  logic [UNIT_W-1:0] exit_units;
  logic [PROD_W-1:0] fee_prod;
  logic [SLOT_W:0]   occ_cnt;

  // Legality is judged against the bay state at the start of the cycle; an
  // out-of-range slot never matches any bay, so it is always illegal.
  always_comb begin
    enter_ok   = 1'b0;
    exit_ok    = 1'b0;
    exit_units = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (enter_valid && enter_slot == SLOT_W'(i) && state_q[i] == BAY_FREE) enter_ok = 1'b1;
      if (exit_valid && exit_slot == SLOT_W'(i) && state_q[i] == BAY_OCC) begin
        exit_ok    = 1'b1;
        exit_units = units_q[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    seconds_d = seconds_q;
    sub_d     = sub_q;
    units_d   = units_q;
    occ_cnt   = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (exit_ok && exit_valid && exit_slot == SLOT_W'(i)) begin
        state_d[i]   = BAY_FREE;
        seconds_d[i] = '0;
        sub_d[i]     = '0;
        units_d[i]   = '0;
      end else if (enter_ok && enter_valid && enter_slot == SLOT_W'(i)) begin
        state_d[i]   = BAY_OCC;
        seconds_d[i] = '0;
        sub_d[i]     = '0;
        units_d[i]   = UNIT_W'(1);
      end else if (tick && state_q[i] == BAY_OCC &&
                   !(enter_valid && enter_slot == SLOT_W'(i)) &&
                   !(exit_valid && exit_slot == SLOT_W'(i))) begin
        // Any event aimed at this bay, legal or not, masks the tick for it.
        if (seconds_q[i] != '1) seconds_d[i] = seconds_q[i] + SEC_W'(1);
        if (sub_q[i] == SUB_W'(SEC_PER_UNIT - 1)) begin
          sub_d[i] = '0;
          if (units_q[i] != '1) units_d[i] = units_q[i] + UNIT_W'(1);
        end else begin
          sub_d[i] = sub_q[i] + SUB_W'(1);
        end
      end
      if (state_d[i] == BAY_OCC) occ_cnt = occ_cnt + (SLOT_W+1)'(1);
    end
    free_count_d = (SLOT_W+1)'(NUM_SLOTS) - occ_cnt;
  end

  always_comb begin
    fee_prod    = PROD_W'(exit_units) * PROD_W'(RATE);
    fee_valid_d = exit_ok;
    fee_d       = fee_q;
    fee_slot_d  = fee_slot_q;
    if (exit_ok) begin
      fee_d      = (fee_prod > PROD_W'({FEE_W{1'b1}})) ? '1 : FEE_W'(fee_prod);
      fee_slot_d = exit_slot;
    end
    err_d = (enter_valid && !enter_ok) || (exit_valid && !exit_ok);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        state_q[i]   <= BAY_FREE;
        seconds_q[i] <= '0;
        sub_q[i]     <= '0;
        units_q[i]   <= '0;
      end
      free_count_q <= (SLOT_W+1)'(NUM_SLOTS);
      fee_valid_q  <= 1'b0;
      fee_q        <= '0;
      fee_slot_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      seconds_q    <= seconds_d;
      sub_q        <= sub_d;
      units_q      <= units_d;
      free_count_q <= free_count_d;
      fee_valid_q  <= fee_valid_d;
      fee_q        <= fee_d;
      fee_slot_q   <= fee_slot_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    occupied    = '0;
    sel_seconds = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      occupied[i] = (state_q[i] == BAY_OCC);
      if (sel_slot == SLOT_W'(i)) sel_seconds = seconds_q[i];
    end
  end

  assign free_count = free_count_q;
  assign fee_valid  = fee_valid_q;
  assign fee        = fee_q;
  assign fee_slot   = fee_slot_q;
  assign err        = err_q;

endmodule

// File: tb/tb_parking_timer.sv
// Directed bench for parking_timer: a table of single-cycle vectors followed
// by hand-written multi-cycle sequences (unit rollover, same-cycle events, reset, saturation).
module tb_parking_timer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        tick = 1'b0;
  logic        enter_valid = 1'b0;
  logic [1:0]  enter_slot = '0;
  logic        exit_valid = 1'b0;
  logic [1:0]  exit_slot = '0;
  logic [1:0]  sel_slot = '0;
  logic [3:0]  occupied;
  logic [2:0]  free_count;
  logic [15:0] sel_seconds;
  logic        fee_valid;
  logic [15:0] fee;
  logic [1:0]  fee_slot;
  logic        err;

  int n_vec = 0;
  int n_miss = 0;

  parking_timer dut (
    .clock       (clock),
    .reset       (reset),
    .tick        (tick),
    .enter_valid (enter_valid),
    .enter_slot  (enter_slot),
    .exit_valid  (exit_valid),
    .exit_slot   (exit_slot),
    .sel_slot    (sel_slot),
    .occupied    (occupied),
    .free_count  (free_count),
    .sel_seconds (sel_seconds),
    .fee_valid   (fee_valid),
    .fee         (fee),
    .fee_slot    (fee_slot),
    .err         (err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic        tck;
    logic        ev;
    logic [1:0]  es;
    logic        xv;
    logic [1:0]  xs;
    logic [1:0]  sel;
    logic [3:0]  occ;
    logic [2:0]  free;
    logic [15:0] sec;
    logic        fv;
    logic [15:0] fee;
    logic [1:0]  fslot;
    logic        er;
  } vec_t;

  vec_t vecs[$];

  // Inputs change 1ns after the rising edge; outputs are sampled there too.
  task automatic drive(input logic rst, input logic tck, input logic ev, input logic [1:0] es,
                       input logic xv, input logic [1:0] xs);
    reset       = rst;
    tick        = tck;
    enter_valid = ev;
    enter_slot  = es;
    exit_valid  = xv;
    exit_slot   = xs;
    @(posedge clock);
    #1;
    reset       = 1'b0;
    tick        = 1'b0;
    enter_valid = 1'b0;
    exit_valid  = 1'b0;
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e_occ, input logic [2:0] e_free,
                         input logic [15:0] e_sec, input logic e_fv, input logic [15:0] e_fee,
                         input logic [1:0] e_fslot, input logic e_err);
    n_vec++;
    cmp({tag, ".occupied"},    32'(occupied),    32'(e_occ));
    cmp({tag, ".free_count"},  32'(free_count),  32'(e_free));
    cmp({tag, ".sel_seconds"}, 32'(sel_seconds), 32'(e_sec));
    cmp({tag, ".fee_valid"},   32'(fee_valid),   32'(e_fv));
    cmp({tag, ".fee"},         32'(fee),         32'(e_fee));
    cmp({tag, ".fee_slot"},    32'(fee_slot),    32'(e_fslot));
    cmp({tag, ".err"},         32'(err),         32'(e_err));
  endtask

  // Park in bay 0 for n ticks, then leave; fee is billed per started unit.
  task automatic run_units(input int n, input logic [15:0] prev_fee, input logic [15:0] exp_fee);
    sel_slot = 2'd0;
    drive(0, 0, 1, 2'd0, 0, 2'd0);
    repeat (n) drive(0, 1, 0, 2'd0, 0, 2'd0);
    chk_all($sformatf("units%0d_stay", n), 4'b0001, 3'd3, 16'(n), 0, prev_fee, 2'd0, 0);
    drive(0, 0, 0, 2'd0, 1, 2'd0);
    chk_all($sformatf("units%0d_exit", n), 4'b0000, 3'd4, 16'd0, 1, exp_fee, 2'd0, 0);
  endtask

  initial begin
    //               rst tck ev es xv xs sel  occ      free sec fv fee  fsl er
    vecs.push_back('{1, 0, 0, 0, 0, 0, 0, 4'b0000, 4, 0, 0, 0,  0, 0}); // reset
    vecs.push_back('{0, 0, 1, 2, 0, 0, 2, 4'b0100, 3, 0, 0, 0,  0, 0}); // enter bay 2
    vecs.push_back('{0, 1, 0, 0, 0, 0, 2, 4'b0100, 3, 1, 0, 0,  0, 0});
    vecs.push_back('{0, 1, 0, 0, 0, 0, 2, 4'b0100, 3, 2, 0, 0,  0, 0});
    vecs.push_back('{0, 1, 0, 0, 0, 0, 2, 4'b0100, 3, 3, 0, 0,  0, 0});
    vecs.push_back('{0, 0, 0, 0, 1, 2, 2, 4'b0000, 4, 0, 1, 10, 2, 0}); // exit bay 2
    vecs.push_back('{0, 0, 0, 0, 0, 0, 2, 4'b0000, 4, 0, 0, 10, 2, 0}); // fee holds
    vecs.push_back('{0, 0, 0, 0, 1, 1, 2, 4'b0000, 4, 0, 0, 10, 2, 1}); // exit free bay 1
    vecs.push_back('{0, 0, 1, 3, 0, 0, 3, 4'b1000, 3, 0, 0, 10, 2, 0}); // enter bay 3
    vecs.push_back('{0, 0, 1, 3, 0, 0, 3, 4'b1000, 3, 0, 0, 10, 2, 1}); // enter bay 3 again
    vecs.push_back('{0, 0, 0, 0, 0, 0, 3, 4'b1000, 3, 0, 0, 10, 2, 0}); // err is a pulse
    vecs.push_back('{0, 0, 0, 0, 1, 3, 3, 4'b0000, 4, 0, 1, 10, 3, 0}); // exit bay 3
    vecs.push_back('{0, 0, 1, 2, 0, 0, 2, 4'b0100, 3, 0, 0, 10, 3, 0}); // enter bay 2
    vecs.push_back('{0, 1, 1, 2, 1, 2, 2, 4'b0000, 4, 0, 1, 10, 2, 1}); // enter+exit occupied bay
    vecs.push_back('{0, 0, 1, 1, 1, 1, 1, 4'b0010, 3, 0, 0, 10, 2, 1}); // enter+exit free bay
    vecs.push_back('{0, 1, 0, 0, 0, 0, 1, 4'b0010, 3, 1, 0, 10, 2, 0});
    vecs.push_back('{0, 1, 1, 0, 1, 1, 0, 4'b0001, 3, 0, 1, 10, 1, 0}); // tick+exit 1+enter 0
    vecs.push_back('{0, 1, 0, 0, 0, 0, 0, 4'b0001, 3, 1, 0, 10, 1, 0});
    vecs.push_back('{0, 0, 0, 0, 1, 0, 0, 4'b0000, 4, 0, 1, 10, 0, 0}); // exit bay 0

    @(posedge clock);
    #1;
    foreach (vecs[k]) begin
      sel_slot = vecs[k].sel;
      drive(vecs[k].rst, vecs[k].tck, vecs[k].ev, vecs[k].es, vecs[k].xv, vecs[k].xs);
      chk_all($sformatf("vec%0d", k), vecs[k].occ, vecs[k].free, vecs[k].sec, vecs[k].fv,
              vecs[k].fee, vecs[k].fslot, vecs[k].er);
    end

    run_units(60, 16'd10, 16'd20);
    run_units(59, 16'd20, 16'd10);
    run_units(120, 16'd10, 16'd30);

    // Bay 0 sits at sub=59; the tick that would roll it over coincides with its exit.
    sel_slot = 2'd1;
    drive(0, 0, 1, 2'd0, 0, 2'd0);
    repeat (59) drive(0, 1, 0, 2'd0, 0, 2'd0);
    drive(0, 1, 1, 2'd1, 1, 2'd0);
    chk_all("tick_exit_enter", 4'b0010, 3'd3, 16'd0, 1, 16'd10, 2'd0, 0);
    drive(0, 1, 0, 2'd0, 0, 2'd0);
    chk_all("bay1_ticks", 4'b0010, 3'd3, 16'd1, 0, 16'd10, 2'd0, 0);
    drive(0, 0, 0, 2'd0, 1, 2'd1);
    chk_all("bay1_exit", 4'b0000, 3'd4, 16'd0, 1, 16'd10, 2'd1, 0);

    // Fill every bay, then reset alongside a tick and an exit.
    sel_slot = 2'd3;
    for (int b = 0; b < 4; b++) drive(0, 0, 1, 2'(b), 0, 2'd0);
    drive(0, 1, 0, 2'd0, 0, 2'd0);
    drive(0, 1, 0, 2'd0, 0, 2'd0);
    chk_all("all_full", 4'b1111, 3'd0, 16'd2, 0, 16'd10, 2'd1, 0);
    drive(1, 1, 0, 2'd0, 1, 2'd0);
    chk_all("reset_busy", 4'b0000, 3'd4, 16'd0, 0, 16'd0, 2'd0, 0);
    drive(0, 0, 0, 2'd0, 0, 2'd0);
    chk_all("after_reset", 4'b0000, 3'd4, 16'd0, 0, 16'd0, 2'd0, 0);

    // Long stay: seconds pins at 65535, units at 255, so the fee is 2550.
    sel_slot = 2'd0;
    drive(0, 0, 1, 2'd0, 0, 2'd0);
    repeat (70000) drive(0, 1, 0, 2'd0, 0, 2'd0);
    chk_all("sec_saturate", 4'b0001, 3'd3, 16'd65535, 0, 16'd0, 2'd0, 0);
    drive(0, 0, 0, 2'd0, 1, 2'd0);
    chk_all("units_saturate", 4'b0000, 3'd4, 16'd0, 1, 16'd2550, 2'd0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
